// File: rtl/board_link_pkg.sv
// Shared definitions for the inter-board serial link (receiver and transmitter).
// Holds frame geometry, default bit timing, receiver state encoding and the parity helper.
package board_link_pkg;

    localparam int FRAME_BITS           = 162;
    localparam int CLKS_PER_BIT_DEFAULT = 564;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Even-parity bit: the value that makes payload XOR parity equal to zero.
    function automatic logic even_parity(input logic [FRAME_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/board_link_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so an idle-high line can reset to 1.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/board_link_rx.sv
// Serial receiver for the inter-board link: start, 162 payload bits LSB first,
// even parity, stop. Emits a one-cycle ready with the frame, or a one-cycle frame_err.
module board_link_rx
    import board_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_in_n,
    input  logic                  rx,
    output logic                  ready,
    output logic [FRAME_BITS-1:0] data_out,
    output logic                  frame_err
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(FRAME_BITS);

    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    rx_state_t             state_r;
    rx_state_t             state_nxt_s;

    logic                  rx_sync_s;
    logic                  rx_prev_r;
    logic [BAUD_W-1:0]     baud_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic                  parity_r;
    logic                  ready_r;
    logic                  frame_err_r;
    logic [FRAME_BITS-1:0] data_out_r;

    logic                  baud_hit_s;
    logic                  parity_ok_s;
    logic                  frame_ok_s;
    logic                  frame_bad_s;

    // The line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk_in),
        .rst_n (rst_in_n),
        .d     (rx),
        .q     (rx_sync_s)
    );

    // Receiver state register.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; every bit decision is taken at a baud_hit_s sample point.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx_prev_r && !rx_sync_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (baud_hit_s) begin
                    state_nxt_s = rx_sync_s ? IDLE : DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (baud_hit_s && (bit_cnt_r == BIT_LAST)) begin
                    state_nxt_s = PARITY;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (baud_hit_s) begin
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                if (baud_hit_s) begin
                    state_nxt_s = rx_sync_s ? IDLE : BREAK;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            BREAK: begin
                if (rx_sync_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BREAK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Sample-point and frame verdict decode.
    always_comb begin
        baud_hit_s  = 1'b0;
        parity_ok_s = (even_parity(shift_r) == parity_r);
        frame_ok_s  = 1'b0;
        frame_bad_s = 1'b0;
        case (state_r)
            START: begin
                baud_hit_s = (baud_r == BAUD_HALF);
            end
            DATA, PARITY, STOP: begin
                baud_hit_s = (baud_r == BAUD_FULL);
            end
            default: begin
                baud_hit_s = 1'b0;
            end
        endcase
        if ((state_r == STOP) && baud_hit_s) begin
            frame_ok_s  = rx_sync_s && parity_ok_s;
            frame_bad_s = !(rx_sync_s && parity_ok_s);
        end else begin
            frame_ok_s  = 1'b0;
            frame_bad_s = 1'b0;
        end
    end

    // Bit timing, payload shifting and parity capture.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rx_prev_r <= 1'b1;
            baud_r    <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            parity_r  <= 1'b0;
        end else begin
            rx_prev_r <= rx_sync_s;
            if ((state_r == IDLE) || (state_r == BREAK) || baud_hit_s) begin
                baud_r <= '0;
            end else begin
                baud_r <= baud_r + BAUD_ONE;
            end
            if ((state_r == DATA) && baud_hit_s) begin
                shift_r <= {rx_sync_s, shift_r[FRAME_BITS-1:1]};
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_r <= '0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + BIT_ONE;
                end
            end else begin
                shift_r   <= shift_r;
                bit_cnt_r <= bit_cnt_r;
            end
            if ((state_r == PARITY) && baud_hit_s) begin
                parity_r <= rx_sync_s;
            end else begin
                parity_r <= parity_r;
            end
        end
    end

    // Registered outputs; data_out changes only together with a ready pulse.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            ready_r     <= 1'b0;
            frame_err_r <= 1'b0;
            data_out_r  <= '0;
        end else begin
            ready_r     <= frame_ok_s;
            frame_err_r <= frame_bad_s;
            if (frame_ok_s) begin
                data_out_r <= shift_r;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign ready     = ready_r;
    assign frame_err = frame_err_r;
    assign data_out  = data_out_r;

endmodule
